// File: rtl/regbank_seq_ctrl.sv
// Read/execute/writeback sequencer for the 8x32 register bank and external ALU.
// Optional macro REGBANK_R0_PROTECT_EN suppresses bank writes to R0.
module regbank_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [OP_W-1:0]   INSTR_OP,
  input  logic [ADDR_W-1:0] INSTR_RS1,
  input  logic [ADDR_W-1:0] INSTR_RS2,
  input  logic [ADDR_W-1:0] INSTR_RD,
  output logic [ADDR_W-1:0] SRC_REG1,
  output logic [ADDR_W-1:0] SRC_REG2,
  output logic              RD_EN,
  output logic [OP_W-1:0]   ALU_OP,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic [ADDR_W-1:0] DEST_REG,
  output logic [DATA_W-1:0] WRT_DATA,
  output logic              WR_EN,
  output logic              DONE,
  output logic              ZERO,
  output logic [CNT_W-1:0]  RETIRED_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  localparam logic [OP_W-1:0] OP_CMP = '1;

  state_t state, state_nxt;

  logic              live;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              wr_allow;

  assign accept = INSTR_VALID && INSTR_READY;

  // live holds READY low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      live     <= 1'b0;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (accept) begin
        op_q  <= INSTR_OP;
        rs1_q <= INSTR_RS1;
        rs2_q <= INSTR_RS2;
        rd_q  <= INSTR_RD;
      end
      if (state == EXEC) begin
        result_q <= ALU_RESULT;
        zero_q   <= (ALU_RESULT == '0);
      end
      if (state == WB) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef REGBANK_R0_PROTECT_EN
  assign wr_allow = (op_q != OP_CMP) && (rd_q != '0);
`else
  assign wr_allow = (op_q != OP_CMP);
`endif

  always_comb begin
    state_nxt   = state;
    INSTR_READY = 1'b0;
    RD_EN       = 1'b0;
    WR_EN       = 1'b0;
    DONE        = 1'b0;
    unique case (state)
      IDLE: begin
        INSTR_READY = live;
        if (INSTR_VALID && live) state_nxt = READ;
      end
      READ: begin
        RD_EN     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        DONE      = 1'b1;
        WR_EN     = wr_allow;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign SRC_REG1    = rs1_q;
  assign SRC_REG2    = rs2_q;
  assign ALU_OP      = op_q;
  assign DEST_REG    = rd_q;
  assign WRT_DATA    = result_q;
  assign ZERO        = zero_q;
  assign RETIRED_CNT = cnt_q;

endmodule

// File: tb/tb_regbank_seq_ctrl.sv
// Directed bench for regbank_seq_ctrl with a bank and ALU model.
// A narrow-counter second instance exercises counter wrap in few cycles.
module tb_regbank_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rs1, instr_rs2, instr_rd;
  logic        instr_ready;
  logic [2:0]  src_reg1, src_reg2, dest_reg;
  logic        rd_en, wr_en, done, zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_result, wrt_data;
  logic [15:0] retired_cnt;

  logic        s_ready, s_rd_en, s_wr_en, s_done, s_zero;
  logic [2:0]  s_src1, s_src2, s_dest;
  logic [3:0]  s_alu_op;
  logic [31:0] s_wrt_data;
  logic [2:0]  s_cnt;

  logic [31:0] bank [8];
  logic [31:0] reg1_data, reg2_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regbank_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready),
    .INSTR_OP(instr_op), .INSTR_RS1(instr_rs1),
    .INSTR_RS2(instr_rs2), .INSTR_RD(instr_rd),
    .SRC_REG1(src_reg1), .SRC_REG2(src_reg2),
    .RD_EN(rd_en), .ALU_OP(alu_op), .ALU_RESULT(alu_result),
    .DEST_REG(dest_reg), .WRT_DATA(wrt_data), .WR_EN(wr_en),
    .DONE(done), .ZERO(zero), .RETIRED_CNT(retired_cnt)
  );

  regbank_seq_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .INSTR_VALID(instr_valid), .INSTR_READY(s_ready),
    .INSTR_OP(instr_op), .INSTR_RS1(instr_rs1),
    .INSTR_RS2(instr_rs2), .INSTR_RD(instr_rd),
    .SRC_REG1(s_src1), .SRC_REG2(s_src2),
    .RD_EN(s_rd_en), .ALU_OP(s_alu_op), .ALU_RESULT(alu_result),
    .DEST_REG(s_dest), .WRT_DATA(s_wrt_data), .WR_EN(s_wr_en),
    .DONE(s_done), .ZERO(s_zero), .RETIRED_CNT(s_cnt)
  );

  function automatic logic [31:0] alu(input logic [3:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'hF:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (wr_en) bank[dest_reg] <= wrt_data;
    if (rd_en) begin
      reg1_data <= bank[src_reg1];
      reg2_data <= bank[src_reg2];
    end
  end

  always_comb alu_result = alu(alu_op, reg1_data, reg2_data);

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [2:0] rd);
    instr_op    = op;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_rd    = rd;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = 32'h0;
    bank[1] = 32'd10;
    bank[2] = 32'd20;
    reg1_data   = '0;
    reg2_data   = '0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_rd    = '0;

    tick();
    tick();
    check("rst_ready", instr_ready, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 0);
    check("rst_cnt", retired_cnt, 0);
    rst = 1'b0;
    #1;
    check("rel_ready_low", instr_ready, 0);
    tick();
    check("rel_ready_high", instr_ready, 1);

    // ADD r3 = r1 + r2; fields scrambled after accept
    instr_op = 4'h0; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_rd = 3'd3;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr_rs1 = 3'd7; instr_rs2 = 3'd7; instr_rd = 3'd7; instr_op = 4'h2;
    check("add_rd_en", rd_en, 1);
    check("add_ready_low", instr_ready, 0);
    check("add_src1", src_reg1, 1);
    check("add_src2", src_reg2, 2);
    check("add_read_wr_en", wr_en, 0);
    tick();
    check("add_exec_rd_en", rd_en, 0);
    check("add_exec_done", done, 0);
    check("add_exec_alu_op", alu_op, 4'h0);
    tick();
    check("add_wb_done", done, 1);
    check("add_wb_wr_en", wr_en, 1);
    check("add_wb_dest", dest_reg, 3);
    check("add_wb_data", wrt_data, 30);
    check("add_wb_zero", zero, 0);
    check("add_wb_cnt", retired_cnt, 0);
    tick();
    check("add_idle_done", done, 0);
    check("add_idle_wr_en", wr_en, 0);
    check("add_cnt", retired_cnt, 1);
    check("add_bank_r3", bank[3], 30);
    check("add_idle_ready", instr_ready, 1);

    // compare-only: no writeback, zero flag set
    instr_op = 4'hF; instr_rs1 = 3'd2; instr_rs2 = 3'd2; instr_rd = 3'd5;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("cmp_done", done, 1);
    check("cmp_wr_en", wr_en, 0);
    check("cmp_zero", zero, 1);
    tick();
    check("cmp_cnt", retired_cnt, 2);
    check("cmp_zero_hold", zero, 1);
    check("cmp_bank_r5", bank[5], 0);

    // back-to-back with VALID held high
    instr_op = 4'h0; instr_rs1 = 3'd3; instr_rs2 = 3'd1; instr_rd = 3'd4;
    instr_valid = 1'b1;
    tick();
    check("b2b_e0_ready", instr_ready, 0);
    check("b2b_e0_rd_en", rd_en, 1);
    instr_rs1 = 3'd4; instr_rs2 = 3'd4; instr_rd = 3'd6;
    tick();
    check("b2b_e1_ready", instr_ready, 0);
    check("b2b_e1_rd_en", rd_en, 0);
    tick();
    check("b2b_e2_ready", instr_ready, 0);
    check("b2b_e2_data", wrt_data, 40);
    check("b2b_e2_zero", zero, 0);
    tick();
    check("b2b_e3_ready", instr_ready, 1);
    check("b2b_e3_rd_en", rd_en, 0);
    tick();
    check("b2b_e4_rd_en", rd_en, 1);
    check("b2b_e4_src1", src_reg1, 4);
    instr_op = 4'h1; instr_rs1 = 3'd6; instr_rs2 = 3'd1; instr_rd = 3'd7;
    tick();
    tick();
    check("b2b_e6_dest", dest_reg, 6);
    check("b2b_e6_data", wrt_data, 80);
    tick();
    check("b2b_e7_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    check("b2b_e8_rd_en", rd_en, 1);
    check("b2b_e8_src1", src_reg1, 6);
    tick();
    tick();
    check("b2b_e10_dest", dest_reg, 7);
    check("b2b_e10_data", wrt_data, 70);
    check("b2b_e10_wr_en", wr_en, 1);
    tick();
    check("b2b_cnt", retired_cnt, 5);
    check("b2b_bank_r7", bank[7], 70);

    // reset asserted during EXEC drops the instruction
    instr_op = 4'h0; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_rd = 3'd2;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", instr_ready, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cnt", retired_cnt, 0);
    check("mid_rst_src1", src_reg1, 0);
    check("mid_rst_src2", src_reg2, 0);
    check("mid_rst_dest", dest_reg, 0);
    check("mid_rst_data", wrt_data, 0);
    check("mid_rst_alu_op", alu_op, 0);
    tick();
    check("mid_rst_hold_wr_en", wr_en, 0);
    check("mid_rst_hold_done", done, 0);
    check("mid_rst_bank_r2", bank[2], 20);
    rst = 1'b0;
    #1;
    check("mid_rel_ready_low", instr_ready, 0);
    tick();
    check("mid_rel_ready_high", instr_ready, 1);

    // write to R0
    instr_op = 4'h0; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_rd = 3'd0;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("r0_done", done, 1);
    check("r0_dest", dest_reg, 0);
`ifdef REGBANK_R0_PROTECT_EN
    check("r0_wr_en", wr_en, 0);
`else
    check("r0_wr_en", wr_en, 1);
`endif
    tick();
    check("r0_cnt", retired_cnt, 1);
    check("r0_cnt_small", s_cnt, 1);

    // counter wrap on the 3-bit instance
    for (int k = 0; k < 6; k++) run_instr(4'hF, 3'd1, 3'd2, 3'd1);
    check("wrap_pre_small", s_cnt, 7);
    check("wrap_pre_full", retired_cnt, 7);
    run_instr(4'hF, 3'd1, 3'd2, 3'd1);
    check("wrap_small", s_cnt, 0);
    check("wrap_full", retired_cnt, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
